// File: rtl/command_line_packer.sv
// command_line_packer
//   Splits an ASCII byte stream into lines and packs each line of 1..4 chars
//   into a 32-bit command word, first char in [31:24], unused low bytes zero.
//   Packed words are buffered in a DEPTH-entry FIFO and drained through a
//   valid/ready port. Lines longer than MAXCHARS are dropped and counted.
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   byte_in     ASCII input byte; byte_valid/byte_ready handshake
//   byte_last   marks the final byte of the stream (flushes a partial line)
//   cmd_out     FIFO head (registered); cmd_valid/cmd_ready handshake
//   line_count  words pushed into the FIFO, wraps at 2^16
//   err_count   overlong lines dropped, saturates at 255
module command_line_packer #(
  parameter int DEPTH    = 4,
  parameter int MAXCHARS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [31:0] cmd_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] line_count,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

  state_t      state_reg, state_next, byte_state;
  logic [2:0]  n_reg, n_next;
  logic [31:0] shift_reg, shift_next;
  logic [31:0] ins_word;
  logic [31:0] acc_word;
  logic [15:0] line_count_reg;
  logic [7:0]  err_count_reg;
  logic        push, pop, err_inc;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   cmd_out_reg;

  logic byte_xfer, is_nl, is_cr, is_char;

  assign byte_ready = (count_reg != CW'(DEPTH));
  assign cmd_valid  = (count_reg != '0);
  assign pop        = cmd_valid & cmd_ready;
  assign byte_xfer  = byte_valid & byte_ready;
  assign is_nl      = (byte_in == CH_NL);
  assign is_cr      = (byte_in == CH_CR);
  assign is_char    = ~is_nl & ~is_cr;
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);

  // Current line with byte_in dropped into the lane selected by n_reg.
  genvar gi;
  generate
    for (gi = 0; gi < MAXCHARS; gi++) begin : g_lane
      assign ins_word[31-8*gi -: 8] = (n_reg == 3'(gi)) ? byte_in : shift_reg[31-8*gi -: 8];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      n_reg          <= '0;
      shift_reg      <= '0;
      line_count_reg <= '0;
      err_count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      shift_reg <= shift_next;
      if (push)
        line_count_reg <= line_count_reg + 16'd1;
      if (err_inc && err_count_reg != 8'hFF)
        err_count_reg <= err_count_reg + 8'd1;
    end
  end

  // Next-state logic. byte_state is the state after the byte itself; the
  // stream-end flush is then applied on top of it.
  always_comb begin
    byte_state = state_reg;
    n_next     = n_reg;
    acc_word   = shift_reg;
    if (byte_xfer) begin
      if (is_nl) begin
        byte_state = IDLE;
      end else if (is_char) begin
        case (state_reg)
          IDLE: begin
            byte_state = ACCUM;
            n_next     = 3'd1;
            acc_word   = {byte_in, 24'h0};
          end
          ACCUM: begin
            if (n_reg == 3'(MAXCHARS)) begin
              byte_state = DISCARD;
            end else begin
              n_next   = n_reg + 3'd1;
              acc_word = ins_word;
            end
          end
          default: ;
        endcase
      end
    end
    state_next = (byte_xfer && byte_last) ? IDLE : byte_state;
    // Returning to IDLE clears the line so the next one starts from zeros.
    if (state_next == IDLE) begin
      n_next     = '0;
      shift_next = '0;
    end else begin
      shift_next = acc_word;
    end
  end

  // Outputs of the line FSM. An NL that ends a line already leaves byte_state
  // at IDLE, so a final NL with byte_last pushes only once.
  always_comb begin
    push    = 1'b0;
    err_inc = 1'b0;
    if (byte_xfer) begin
      push    = (is_nl && state_reg == ACCUM) || (byte_last && byte_state == ACCUM);
      err_inc = is_char && state_reg == ACCUM && n_reg == 3'(MAXCHARS);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= acc_word;
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // cmd_out is kept equal to the FIFO head. A word written this cycle is
  // forwarded when it becomes the head so the output has no extra latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      cmd_out_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
        if (count_reg > CW'(1))
          cmd_out_reg <= mem[rd_ptr_inc];
        else if (push)
          cmd_out_reg <= acc_word;
      end else if (count_reg == '0 && push) begin
        cmd_out_reg <= acc_word;
      end
    end
  end

  assign cmd_out    = cmd_out_reg;
  assign line_count = line_count_reg;
  assign err_count  = err_count_reg;

endmodule
